// File: rtl/write_ctrl_af.sv
// Write-domain half of the asynchronous FIFO: owns the write pointers and the RAM write strobe,
// and derives full/almost_full/level/overflow against a locally synchronised read pointer.
module write_ctrl_af #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              w_clk,
    input  logic              w_reset,
    input  logic              w_en,
    input  logic [ADDR_W:0]   rgptr,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic              clr_ovf,
    output logic              mem_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W:0]   bwptr,
    output logic [ADDR_W:0]   gwptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              overflow
);

    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rg_sync;
    logic [ADDR_W:0] rb_sync;
    logic [ADDR_W:0] bw_next;
    logic [ADDR_W:0] gw_next;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] full_gray;
    logic            accept;

    // Only the Gray-coded read pointer crosses domains, so a plain flop chain is safe.
    always_ff @(posedge w_clk or negedge w_reset) begin
        if (!w_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rgptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rg_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rb_sync = '0;
        for (int i = 0; i <= ADDR_W; i++) rb_sync[i] = ^(rg_sync >> i);
    end

    assign accept     = w_en & ~full;
    assign mem_we     = accept;
    assign w_addr     = bwptr[ADDR_W-1:0];
    assign bw_next    = bwptr + {{ADDR_W{1'b0}}, accept};
    assign gw_next    = bw_next ^ (bw_next >> 1);
    assign level_next = bw_next - rb_sync;
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign full_gray  = {~rg_sync[ADDR_W:ADDR_W-1], rg_sync[ADDR_W-2:0]};

    // Flags are computed from the post-edge pointer so full never lags the accepting write.
    always_ff @(posedge w_clk or negedge w_reset) begin
        if (!w_reset) begin
            bwptr       <= '0;
            gwptr       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
        end else begin
            bwptr       <= bw_next;
            gwptr       <= gw_next;
            full        <= (gw_next == full_gray);
            almost_full <= (level_next >= af_thresh);
            w_level     <= level_next;
        end
    end

    // A write attempt while full takes priority over a simultaneous clear.
    always_ff @(posedge w_clk or negedge w_reset) begin
        if (!w_reset) begin
            overflow <= 1'b0;
        end else if (w_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_ctrl_af.sv
// Bench for write_ctrl_af: directed scenarios with literal expectations plus a randomized
// writer/reader run compared every cycle against a count-based FIFO occupancy model.
module tb_write_ctrl_af;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int SYNC  = 2;

    logic          w_clk = 1'b0;
    logic          w_reset = 1'b1;
    logic          w_en = 1'b0;
    logic [PW-1:0] rgptr = '0;
    logic [PW-1:0] af_thresh = 4'd6;
    logic          clr_ovf = 1'b0;
    logic          mem_we;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] bwptr;
    logic [PW-1:0] gwptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] w_level;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words written and words read, as counts modulo twice the depth.
    logic [PW-1:0] rd_ptr = '0;
    logic [PW-1:0] rd_seen [SYNC];
    logic [PW-1:0] m_wr;
    logic [PW-1:0] m_level;
    logic          m_full;
    logic          m_af;
    logic          m_ovf;
    logic [PW-1:0] m_wr_n;
    logic [PW-1:0] m_lvl_n;
    logic [PW-1:0] prev_g;
    logic [PW-1:0] prev_b;
    logic          seen_wrap = 1'b0;
    logic [PW-1:0] rd_next;

    write_ctrl_af #(.ADDR_W(AW), .SYNC_STAGES(SYNC)) dut (
        .w_clk(w_clk), .w_reset(w_reset), .w_en(w_en), .rgptr(rgptr),
        .af_thresh(af_thresh), .clr_ovf(clr_ovf), .mem_we(mem_we), .w_addr(w_addr),
        .bwptr(bwptr), .gwptr(gwptr), .full(full), .almost_full(almost_full),
        .w_level(w_level), .overflow(overflow)
    );

    always #5 w_clk = ~w_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic [PW-1:0] rd);
        w_en    = en;
        clr_ovf = clr;
        rd_ptr  = rd;
        rgptr   = rd ^ (rd >> 1);
        #1;
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    assign m_wr_n  = m_wr + ((w_en && !m_full) ? 4'd1 : 4'd0);
    assign m_lvl_n = m_wr_n - rd_seen[SYNC-1];

    // The write side only learns of reads after the synchroniser delay.
    always @(posedge w_clk or negedge w_reset) begin
        if (!w_reset) begin
            for (int i = 0; i < SYNC; i++) rd_seen[i] <= '0;
            m_wr    <= '0;
            m_level <= '0;
            m_full  <= 1'b0;
            m_af    <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            rd_seen[0] <= rd_ptr;
            for (int i = 1; i < SYNC; i++) rd_seen[i] <= rd_seen[i-1];
            m_wr    <= m_wr_n;
            m_level <= m_lvl_n;
            m_full  <= (int'(m_lvl_n) == DEPTH);
            m_af    <= (m_lvl_n >= af_thresh);
            m_ovf   <= (w_en && m_full) ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
        end
    end

    always @(negedge w_clk or negedge w_reset) begin
        if (!w_reset) begin
            prev_g <= '0;
            prev_b <= '0;
        end else begin
            checkOutput("mem_we", mem_we, (w_en && !m_full));
            checkOutput("w_addr", w_addr, m_wr % DEPTH);
            checkOutput("bwptr", bwptr, m_wr);
            checkOutput("gwptr", gwptr, m_wr ^ (m_wr >> 1));
            checkOutput("full", full, m_full);
            checkOutput("almost_full", almost_full, m_af);
            checkOutput("w_level", w_level, m_level);
            checkOutput("overflow", overflow, m_ovf);
            if (gwptr != prev_g) checkOutput("gwptr_step", $countones(gwptr ^ prev_g), 1);
            if (prev_b == 4'd15 && bwptr == 4'd0) seen_wrap <= 1'b1;
            prev_g <= gwptr;
            prev_b <= bwptr;
        end
    end

    initial begin
        #1 w_reset = 1'b0;
        #1;
        checkOutput("rst_bwptr", bwptr, 0);
        checkOutput("rst_gwptr", gwptr, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_af", almost_full, 0);
        checkOutput("rst_level", w_level, 0);
        checkOutput("rst_ovf", overflow, 0);
        #10 w_reset = 1'b1;
        tick();

        // Fill an empty FIFO; almost_full (threshold 6) rises on the sixth write.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd0);
            checkOutput("fill_mem_we", mem_we, 1);
            checkOutput("fill_addr", w_addr, k);
            tick();
            checkOutput("fill_af", almost_full, (k >= 5) ? 1 : 0);
            if (k == DEPTH - 2) checkOutput("fill_not_full", full, 0);
        end
        checkOutput("fill_full", full, 1);
        checkOutput("fill_level", w_level, 8);
        checkOutput("fill_bwptr", bwptr, 8);

        // Writes while full are dropped and latch overflow; set beats clear.
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("ovf_mem_we", mem_we, 0);
        tick();
        checkOutput("ovf_bwptr1", bwptr, 8);
        checkOutput("ovf_set", overflow, 1);
        tick();
        checkOutput("ovf_bwptr2", bwptr, 8);
        checkOutput("ovf_full", full, 1);
        checkOutput("ovf_sticky", overflow, 1);
        applyStimulus(1'b0, 1'b1, 4'd0);
        tick();
        checkOutput("ovf_clr", overflow, 0);
        applyStimulus(1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("ovf_set_wins", overflow, 1);
        applyStimulus(1'b0, 1'b1, 4'd0);
        tick();
        checkOutput("ovf_clr2", overflow, 0);

        // One read becomes visible after the synchroniser plus the flag register.
        applyStimulus(1'b0, 1'b0, 4'd1);
        tick();
        tick();
        checkOutput("rd_full_hold", full, 1);
        tick();
        checkOutput("rd_full_drop", full, 0);
        checkOutput("rd_level", w_level, 7);

        // Randomized writer with a reader trailing what has been written.
        af_thresh = 4'($urandom_range(1, DEPTH));
        for (int c = 0; c < 400; c++) begin
            rd_next = rd_ptr;
            if (rd_next != m_wr && $urandom_range(0, 1) == 1) rd_next = rd_next + 4'd1;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rd_next);
            tick();
        end
        checkOutput("wrap_seen", seen_wrap, 1);

        // Asynchronous reset in the middle of a burst, well away from a clock edge.
        applyStimulus(1'b1, 1'b0, rd_ptr);
        tick();
        tick();
        #3 w_reset = 1'b0;
        #2;
        checkOutput("arst_bwptr", bwptr, 0);
        checkOutput("arst_gwptr", gwptr, 0);
        checkOutput("arst_addr", w_addr, 0);
        checkOutput("arst_full", full, 0);
        checkOutput("arst_af", almost_full, 0);
        checkOutput("arst_level", w_level, 0);
        checkOutput("arst_ovf", overflow, 0);
        af_thresh = 4'd0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        #6 w_reset = 1'b1;
        tick();
        checkOutput("af0_high", almost_full, 1);
        checkOutput("af0_level", w_level, 0);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("post_rst_addr", w_addr, 0);
        checkOutput("post_rst_we", mem_we, 1);
        tick();
        checkOutput("post_rst_bwptr", bwptr, 1);

        // Threshold above the depth keeps almost_full low even when full.
        af_thresh = 4'd9;
        for (int k = 1; k < DEPTH; k++) tick();
        checkOutput("af9_full", full, 1);
        checkOutput("af9_level", w_level, 8);
        checkOutput("af9_low", almost_full, 0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
